regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file: the next generation of the CPU's 16×16 operand store. It provides:
- configurable width and depth;
- `NUM_RD` independent combinational read ports;
- one byte-enabled write port with optional write-to-read bypass;
- a sequential clear engine that zeroes the array one entry per cycle after reset or on request.

It sits between the control unit and the ALU operand path. It replaces the single-port bank where two operands must be fetched in the same cycle.

## Interface
Parameters:
- `DATA_W`, 16, word width in bits; must be a multiple of 8.
- `DEPTH`, 16, number of entries; must be ≥ 2.
- `ADDR_W`, `$clog2(DEPTH)`, address width.
- `NUM_RD`, 2, number of read ports; must be ≥ 1.
- `BYPASS`, 1, 1 = a same-cycle accepted write is forwarded to matching reads.
- `CLR_VAL`, 0, value written by the clear engine.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `clear_req`  in  1  starts a full-array clear.
- `ready`  out  1  high when the array is initialised and accepting writes.
- `wr_en`  in  1  write request.
- `wr_addr`  in  `ADDR_W`  write address.
- `wr_data`  in  `DATA_W`  write data.
- `wr_be`  in  `DATA_W/8`  byte enables; bit k covers bits `[8k+7:8k]`.
- `wr_err`  out  1  registered one-cycle pulse for a rejected write.
- `rd_addr`  in  `NUM_RD*ADDR_W`  packed read addresses; port p uses slice p.
- `rd_data`  out  `NUM_RD*DATA_W`  packed read data; combinational.

## Operation
- FSM states:
  - `CLEAR`: the engine writes `CLR_VAL` to `mem[clr_ptr]`, then `clr_ptr++`. When `clr_ptr==DEPTH-1`, the next state is `IDLE` and `ready` goes to 1.
  - `IDLE`: normal operation. If `clear_req` is sampled high, the next state is `CLEAR` with `clr_ptr` = 0 and `ready` = 0.
- `clear_req` while in `CLEAR` is ignored; the sweep is not restarted.
- A write is accepted when `ready && wr_en && !clear_req && wr_addr < DEPTH`.
  - Only lanes with `wr_be[k]=1` are updated.
  - `wr_be` = 0 is accepted as a no-op; `wr_err` = 0.
- A write is rejected when `wr_en` is high and any of these holds: `!ready`, `clear_req`, or `wr_addr >= DEPTH`.
  - The array is unchanged and `wr_err` = 1 on the next cycle.
- Reads:
  - `rd_data[p] = mem[rd_addr[p]]`.
  - If `rd_addr[p] >= DEPTH`, the port returns 0.
  - While `!ready`, every port returns `CLR_VAL`.
- Bypass:
  - With `BYPASS=1`, if a write is accepted this cycle and `rd_addr[p]==wr_addr`, port p returns the byte-merged new word: `wr_data` in enabled lanes, old `mem` contents elsewhere.
  - With `BYPASS=0`, port p returns the old word; the new value is visible from the next cycle.
- Any number of read ports may address the same entry simultaneously.

## Timing
- `reset` high at edge E0 gives: state = `CLEAR`, `clr_ptr` = 0, `ready` = 0, `wr_err` = 0. Array contents are undefined until cleared.
- The clear sweep takes exactly `DEPTH` cycles:
  - Edges E1..E_DEPTH write entries 0..DEPTH-1.
  - `ready` = 1 after edge E_DEPTH.
  - `reset` held high keeps the FSM at `CLEAR` with `clr_ptr` = 0.
- `clear_req` sampled at edge Ec means `ready` = 0 after Ec, and `ready` = 1 after edge Ec+DEPTH.
- Write latency: array updated at the accepting edge; 0 cycles through bypass; 1 cycle without bypass.
- `wr_err`: asserted for the cycle after the offending edge; it is re-evaluated every cycle.
- `reset` mid-sweep or mid-write: reset wins. The in-flight write is dropped and no `wr_err` pulse is produced.

## Structure
- Shared package `cpu_mem_pkg`:
  - FSM state enum `rf_state_t {RF_CLEAR, RF_IDLE}`;
  - byte-lane constant `BYTE_W = 8`;
  - function `be_merge(old, new, be)`, used by both the write path and the bypass path.
- Sub-module `regfile_clear_fsm`: owns the state, `clr_ptr` and `ready`. It outputs `clr_we` and `clr_addr` to the array.
- Top level: array, write arbitration between clear and user writes, read mux per port, bypass compare, `wr_err` register.

## Test plan
- Reset, then count cycles with `DEPTH=16` → `ready` rises exactly 16 cycles after `reset` deasserts. During the sweep all `rd_data` = `CLR_VAL`, and a write to addr 3 produces `wr_err` = 1 one cycle later and is not stored.
- Write 0xBEEF to addr 5, `wr_be`=2'b11; next cycle read port0=5, port1=5 → both return 0xBEEF.
- Given addr 7 = 0x1234, write 0xAB00 with `wr_be`=2'b10 → addr 7 reads 0xAB34. With `BYPASS=1` the same cycle shows 0xAB34; with `BYPASS=0` the same cycle shows 0x1234.
- `DEPTH=12`, write to addr 13 → `wr_err` = 1 and the array is unchanged. A read of addr 14 returns 0.
- `clear_req` and `wr_en` (addr 2, 0x5555) in the same cycle → `wr_err` = 1, `ready` = 0 for 16 cycles, and afterwards addr 2 reads 0.
- Assert `reset` at clear cycle 8, then release → `clr_ptr` restarts at 0, `ready` is asserted 16 cycles after release, and all entries read `CLR_VAL`.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the CPU operand store.
package cpu_mem_pkg;

  typedef enum logic {RF_CLEAR, RF_IDLE} rf_state_t;

  localparam int BYTE_W = 8;

  // Upper bound on word width handled by be_merge; callers zero-extend into it.
  localparam int MAX_W  = 256;
  localparam int MAX_BE = MAX_W / BYTE_W;

  // Byte-lane merge: lanes with be[k] set take new_word, the rest keep old_word.
  function automatic logic [MAX_W-1:0] be_merge(input logic [MAX_W-1:0]  old_word,
                                                input logic [MAX_W-1:0]  new_word,
                                                input logic [MAX_BE-1:0] be);
    logic [MAX_W-1:0] res;
    res = old_word;
    for (int k = 0; k < MAX_BE; k++) begin
      if (be[k]) res[k*BYTE_W +: BYTE_W] = new_word[k*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: sweeps the array with CLR_VAL after reset or on request.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RF_CLEAR | writing CLR_VAL to entry clr_ptr, one entry per cycle
// RF_IDLE  | array initialised, user writes accepted, ready = 1
module regfile_clear_fsm
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  rf_state_t         state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;

  // State and sweep pointer registers; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RF_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // Next-state logic; clear_req during a sweep is ignored.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      RF_CLEAR: begin
        if (clr_ptr == LAST_ADDR) begin
          state_nxt   = RF_IDLE;
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + 1'b1;
        end
      end
      RF_IDLE: begin
        if (clear_req) begin
          state_nxt   = RF_CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt   = RF_CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  assign ready    = (state == RF_IDLE);
  // The reset edge itself writes nothing; the sweep starts on the edge after.
  assign clr_we   = (state == RF_CLEAR) && !reset;
  assign clr_addr = clr_ptr;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, one byte-enabled
// write port with optional same-cycle bypass, and a sequential clear engine.
module regfile_mp
  import cpu_mem_pkg::*;
#(
  parameter int              DATA_W  = 16,
  parameter int              DEPTH   = 16,
  parameter int              ADDR_W  = $clog2(DEPTH),
  parameter int              NUM_RD  = 2,
  parameter int              BYPASS  = 1,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_req,
  output logic                     ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  output logic                     wr_err,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data
);

  localparam int              BE_W    = DATA_W / BYTE_W;
  // One extra bit so DEPTH itself is representable for non-power-of-two depths.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_in_range;
  logic              wr_acc;
  logic              wr_rej;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_merged;

  regfile_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .ready     (ready),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
  assign wr_acc      = ready && wr_en && !clear_req && wr_in_range && !reset;
  assign wr_rej      = wr_en && !(ready && !clear_req && wr_in_range);
  assign wr_idx      = wr_in_range ? wr_addr : '0;
  // Same merged word feeds the array and the bypass path.
  assign wr_merged   = DATA_W'(be_merge(MAX_W'(mem[wr_idx]), MAX_W'(wr_data),
                                        MAX_BE'(wr_be)));

  // Array update: the clear engine owns the array while ready is low.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= CLR_VAL;
    end else if (wr_acc) begin
      mem[wr_addr] <= wr_merged;
    end
  end

  // Rejected-write flag, one cycle after the offending edge; reset suppresses it.
  always_ff @(posedge clk) begin
    if (reset) wr_err <= 1'b0;
    else       wr_err <= wr_rej;
  end

  // Per-port read mux with out-of-range zeroing and optional write bypass.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    rd_data = '0;
    ra      = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra = rd_addr[p*ADDR_W +: ADDR_W];
      if (!ready) begin
        rd_data[p*DATA_W +: DATA_W] = CLR_VAL;
      end else if ({1'b0, ra} >= DEPTH_C) begin
        rd_data[p*DATA_W +: DATA_W] = '0;
      end else if ((BYPASS != 0) && wr_acc && (ra == wr_addr)) begin
        rd_data[p*DATA_W +: DATA_W] = wr_merged;
      end else begin
        rd_data[p*DATA_W +: DATA_W] = mem[ra];
      end
    end
  end

  logic unused_be_w;
  assign unused_be_w = (BE_W == 0);

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypass instance, one non-bypass instance
// with a non-zero clear value, and one 12-entry instance, all sharing stimulus.
module tb_regfile_mp;

  logic        clk;
  logic        reset;
  logic        clear_req;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic [7:0]  rd_addr;

  logic        ready_a, err_a;
  logic [31:0] rd_a;
  logic        ready_n, err_n;
  logic [31:0] rd_n;
  logic        ready_x, err_x;
  logic [31:0] rd_x;

  int n_tests;
  int n_fail;

  regfile_mp #(.BYPASS(1)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_err(err_a), .rd_addr(rd_addr), .rd_data(rd_a)
  );

  regfile_mp #(.BYPASS(0), .CLR_VAL(16'hA5A5)) dut_nb (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_err(err_n), .rd_addr(rd_addr), .rd_data(rd_n)
  );

  regfile_mp #(.DEPTH(12)) dut12 (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_x),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_err(err_x), .rd_addr(rd_addr), .rd_data(rd_x)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [1:0]  be;
    logic [3:0]  ra0, ra1;
    logic [15:0] e0, e1;   // bypass instance
    logic [15:0] n0, n1;   // non-bypass instance, CLR_VAL A5A5
    logic [15:0] x0, x1;   // 12-entry instance
    logic        err, xerr;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [15:0] fill;
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    clear_req = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = 4'd0;
    wr_data   = 16'h0000;
    wr_be     = 2'b00;
    rd_addr   = {4'd7, 4'd3};

    //            we    wa     wd        be     ra0    ra1    e0        e1        n0        n1        x0        x1        err   xerr
    vecs[0]  = '{1'b1, 4'd5,  16'hBEEF, 2'b11, 4'd5,  4'd5,  16'hBEEF, 16'hBEEF, 16'hA5A5, 16'hA5A5, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 4'd5,  4'd5,  16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'd7,  16'h1234, 2'b11, 4'd7,  4'd3,  16'h1234, 16'h0000, 16'hA5A5, 16'hA5A5, 16'h1234, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'd7,  16'hAB00, 2'b10, 4'd7,  4'd7,  16'hAB34, 16'hAB34, 16'h1234, 16'h1234, 16'hAB34, 16'hAB34, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 4'd7,  4'd5,  16'hAB34, 16'hBEEF, 16'hAB34, 16'hBEEF, 16'hAB34, 16'hBEEF, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'd9,  16'h00CD, 2'b01, 4'd9,  4'd9,  16'h00CD, 16'h00CD, 16'hA5A5, 16'hA5A5, 16'h00CD, 16'h00CD, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 4'd9,  4'd9,  16'h00CD, 16'h00CD, 16'hA5CD, 16'hA5CD, 16'h00CD, 16'h00CD, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'd9,  16'hFFFF, 2'b00, 4'd9,  4'd9,  16'h00CD, 16'h00CD, 16'hA5CD, 16'hA5CD, 16'h00CD, 16'h00CD, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 4'd9,  4'd15, 16'h00CD, 16'h0000, 16'hA5CD, 16'hA5A5, 16'h00CD, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'd13, 16'h1111, 2'b11, 4'd14, 4'd13, 16'h0000, 16'h1111, 16'hA5A5, 16'hA5A5, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 4'd0,  16'h0000, 2'b00, 4'd13, 4'd5,  16'h1111, 16'hBEEF, 16'h1111, 16'hBEEF, 16'h0000, 16'hBEEF, 1'b0, 1'b0};

    // Reset, then count the sweep; a write attempted mid-sweep must be rejected.
    tick();
    tick();
    reset = 1'b0;
    check("reset_ready", {31'd0, ready_a}, 32'd0);
    check("reset_wr_err", {31'd0, err_a}, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("sweep_ready", {31'd0, ready_a}, {31'd0, (i == 16)});
      check("sweep_ready12", {31'd0, ready_x}, {31'd0, (i >= 12)});
      if (i < 16) begin
        check("sweep_rd_clrval", rd_a, 32'h0000_0000);
        check("sweep_rd_clrval_nb", rd_n, 32'hA5A5_A5A5);
      end
      if (i == 4) begin
        check("sweep_wr_err", {31'd0, err_a}, 32'd1);
        check("sweep_wr_err_nb", {31'd0, err_n}, 32'd1);
      end
      if (i == 5) check("sweep_wr_err_drop", {31'd0, err_a}, 32'd0);
      if (i == 3) begin
        wr_en   = 1'b1;
        wr_addr = 4'd3;
        wr_data = 16'h7777;
        wr_be   = 2'b11;
      end
      if (i == 4) wr_en = 1'b0;
    end

    // Table of single-cycle write/read vectors.
    for (int v = 0; v < 11; v++) begin
      wr_en   = vecs[v].we;
      wr_addr = vecs[v].wa;
      wr_data = vecs[v].wd;
      wr_be   = vecs[v].be;
      rd_addr = {vecs[v].ra1, vecs[v].ra0};
      @(negedge clk);
      check($sformatf("vec%0d_rd_bypass", v), rd_a, {vecs[v].e1, vecs[v].e0});
      check($sformatf("vec%0d_rd_nobypass", v), rd_n, {vecs[v].n1, vecs[v].n0});
      check($sformatf("vec%0d_rd_depth12", v), rd_x, {vecs[v].x1, vecs[v].x0});
      tick();
      wr_en = 1'b0;
      check($sformatf("vec%0d_wr_err", v), {31'd0, err_a}, {31'd0, vecs[v].err});
      check($sformatf("vec%0d_wr_err12", v), {31'd0, err_x}, {31'd0, vecs[v].xerr});
    end

    // clear_req collides with a write; a second clear_req mid-sweep is ignored.
    clear_req = 1'b1;
    wr_en     = 1'b1;
    wr_addr   = 4'd2;
    wr_data   = 16'h5555;
    wr_be     = 2'b11;
    tick();
    clear_req = 1'b0;
    wr_en     = 1'b0;
    check("clr_collide_wr_err", {31'd0, err_a}, 32'd1);
    check("clr_collide_wr_err12", {31'd0, err_x}, 32'd1);
    check("clr_collide_ready", {31'd0, ready_a}, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("clr_sweep_ready", {31'd0, ready_a}, {31'd0, (i == 16)});
      if (i == 1) check("clr_wr_err_drop", {31'd0, err_a}, 32'd0);
      if (i == 5) clear_req = 1'b1;
      if (i == 6) clear_req = 1'b0;
    end
    rd_addr = {4'd5, 4'd2};
    #1;
    check("clr_rd_after", rd_a, 32'h0000_0000);
    check("clr_rd_after_nb", rd_n, 32'hA5A5_A5A5);

    // Fill every entry, start a clear, reset part-way through it.
    wr_be = 2'b11;
    for (int a = 0; a < 16; a++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(a);
      wr_data = 16'(a * 16'h1111 + 1);
      tick();
    end
    wr_en   = 1'b0;
    rd_addr = {4'd10, 4'd10};
    #1;
    fill = 16'hAAAB;
    check("fill_rd10", rd_a, {fill, fill});
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 4'd4;
    tick();
    reset = 1'b0;
    wr_en = 1'b0;
    check("rst_mid_wr_err", {31'd0, err_a}, 32'd0);
    check("rst_mid_ready", {31'd0, ready_a}, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("rst_sweep_ready", {31'd0, ready_a}, {31'd0, (i == 16)});
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = {4'(a), 4'(a)};
      #1;
      check($sformatf("rst_clr_rd%0d", a), rd_a, 32'h0000_0000);
      check($sformatf("rst_clr_rd_nb%0d", a), rd_n, 32'hA5A5_A5A5);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
